// File: rtl/hub_responder.sv
// rtl/hub_responder.sv - hub-side responder: round-robin slot, hub RAM access, locks and cogid
// Results come back one clock after the cog's slot as a one-hot ack with bus_q/bus_c.
module hub_responder #(
  parameter int COGS   = 8,
  parameter int ADDR_W = 16,
  parameter int LOCKS  = 8
) (
  input  logic                     clk_cog,
  input  logic                     nres,
  input  logic [COGS-1:0]          req,
  input  logic [3*COGS-1:0]        cog_op,
  input  logic [ADDR_W*COGS-1:0]   cog_addr,
  input  logic [32*COGS-1:0]       cog_data,
  output logic [COGS-1:0]          ack,
  output logic [31:0]              bus_q,
  output logic                     bus_c,
  output logic                     ram_en,
  output logic                     ram_w,
  output logic [3:0]               ram_be,
  output logic [ADDR_W-3:0]        ram_a,
  output logic [31:0]              ram_d,
  input  logic [31:0]              ram_q
);
  localparam int SW = $clog2(COGS);
  localparam int LW = $clog2(LOCKS);

  logic [SW-1:0]    slot_q, slot_d;
  logic [COGS-1:0]  ack_q, ack_d;
  logic             pend_rd_q, pend_rd_d;
  logic [1:0]       pend_size_q, pend_size_d;
  logic [1:0]       pend_a_q, pend_a_d;
  logic [31:0]      res_q, res_d, hold_q, hold_d;
  logic             resc_q, resc_d, holdc_q, holdc_d;
  logic [LOCKS-1:0] alloc_q, alloc_d, lstate_q, lstate_d;

  logic              issue, is_mem, free_found;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data, shaped;
  logic [LW-1:0]     lid, free_id;

  always_comb begin
    slot_d      = slot_q + 1'b1;
    op          = cog_op[3*int'(slot_q) +: 3];
    addr        = cog_addr[ADDR_W*int'(slot_q) +: ADDR_W];
    data        = cog_data[32*int'(slot_q) +: 32];
    issue       = req[slot_q];
    is_mem      = (op[1:0] != 2'b11);
    lid         = data[LW-1:0];
    ram_en      = issue && is_mem && nres;
    ram_w       = ram_en && op[2];
    ram_a       = addr[ADDR_W-1:2];
    ram_be      = 4'b1111;
    ram_d       = data;
    alloc_d     = alloc_q;
    lstate_d    = lstate_q;
    res_d       = res_q;
    resc_d      = resc_q;
    ack_d       = '0;
    pend_rd_d   = issue && is_mem && !op[2];
    pend_size_d = op[1:0];
    pend_a_d    = addr[1:0];
    free_found  = 1'b0;
    free_id     = '0;

    case (op[1:0])
      2'b00:   begin ram_be = 4'b0001 << addr[1:0];           ram_d = {4{data[7:0]}};  end
      2'b01:   begin ram_be = addr[1] ? 4'b1100 : 4'b0011;    ram_d = {2{data[15:0]}}; end
      default: begin ram_be = 4'b1111;                        ram_d = data;            end
    endcase

    // Descending scan so the lowest free id is the one left standing.
    for (int i = LOCKS-1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_found = 1'b1;
        free_id    = LW'(i);
      end
    end

    if (issue) begin
      ack_d[slot_q] = 1'b1;
      if (op == 3'b111) begin
        res_d  = 32'(slot_q);
        resc_d = 1'b0;
      end else if (op == 3'b011) begin
        case (addr[1:0])
          2'b00: begin
            if (free_found) begin
              alloc_d[free_id] = 1'b1;
              res_d  = 32'(free_id);
              resc_d = 1'b0;
            end else begin
              res_d  = '0;
              resc_d = 1'b1;
            end
          end
          2'b01: begin
            alloc_d[lid]  = 1'b0;
            lstate_d[lid] = 1'b0;
            res_d  = 32'(lid);
            resc_d = 1'b0;
          end
          2'b10: begin
            lstate_d[lid] = 1'b1;
            res_d  = 32'(lid);
            resc_d = lstate_q[lid];
          end
          default: begin
            lstate_d[lid] = 1'b0;
            res_d  = 32'(lid);
            resc_d = lstate_q[lid];
          end
        endcase
      end else if (op[2]) begin
        res_d  = ram_d;
        resc_d = 1'b0;
      end
    end
  end

  always_comb begin
    case (pend_size_q)
      2'b00:   shaped = {24'h0, ram_q[{pend_a_q, 3'b000} +: 8]};
      2'b01:   shaped = {16'h0, pend_a_q[1] ? ram_q[31:16] : ram_q[15:0]};
      default: shaped = ram_q;
    endcase
    ack     = ack_q;
    bus_q   = hold_q;
    bus_c   = holdc_q;
    if (|ack_q) begin
      bus_q = pend_rd_q ? shaped : res_q;
      bus_c = pend_rd_q ? 1'b0 : resc_q;
    end
    hold_d  = bus_q;
    holdc_d = bus_c;
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      slot_q      <= '0;
      ack_q       <= '0;
      pend_rd_q   <= 1'b0;
      pend_size_q <= '0;
      pend_a_q    <= '0;
      res_q       <= '0;
      resc_q      <= 1'b0;
      hold_q      <= '0;
      holdc_q     <= 1'b0;
      alloc_q     <= '0;
      lstate_q    <= '0;
    end else begin
      slot_q      <= slot_d;
      ack_q       <= ack_d;
      pend_rd_q   <= pend_rd_d;
      pend_size_q <= pend_size_d;
      pend_a_q    <= pend_a_d;
      res_q       <= res_d;
      resc_q      <= resc_d;
      hold_q      <= hold_d;
      holdc_q     <= holdc_d;
      alloc_q     <= alloc_d;
      lstate_q    <= lstate_d;
    end
  end
endmodule
